// File: rtl/pixel_pkg.sv
// pixel_pkg: widths, lane indexing and byte-lane helpers shared by the pixel
// packer and the quad-to-pixel serializer.
package pixel_pkg;

  localparam int PIX_W      = 8;
  localparam int QUAD_LANES = 4;
  localparam int QUAD_W     = PIX_W * QUAD_LANES;

  typedef logic [1:0] lane_idx_t;
  localparam lane_idx_t LAST_LANE = 2'd3;

  typedef enum logic {
    FILLING = 1'b0,
    HOLDING = 1'b1
  } pack_state_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

  typedef struct packed {
    logic [QUAD_W-1:0] r;
    logic [QUAD_W-1:0] g;
    logic [QUAD_W-1:0] b;
  } quad_t;

  // Lane 0 is the most significant byte, so the first pixel lands in [31:24].
  function automatic int lane_lsb(input lane_idx_t idx);
    return QUAD_W - PIX_W * (int'(idx) + 1);
  endfunction

  function automatic logic [QUAD_W-1:0] put_lane(input logic [QUAD_W-1:0] word,
                                                 input lane_idx_t         idx,
                                                 input logic [PIX_W-1:0]  px);
    logic [QUAD_W-1:0] w;
    w = word;
    w[lane_lsb(idx) +: PIX_W] = px;
    return w;
  endfunction

  // Lanes 0..idx valid: top idx+1 bits of the mask set.
  function automatic logic [QUAD_LANES-1:0] fill_mask(input lane_idx_t idx);
    logic [QUAD_LANES-1:0] m;
    m = '1;
    return m << (LAST_LANE - idx);
  endfunction

endpackage

// File: rtl/pixel_quad_packer.sv
// pixel_quad_packer: packs single RGB pixels into 32-bit per-channel quads on a
// valid/ready output. Optional macro PIXEL_PACK_LAST_EN adds pix_last/quad_mask.
module pixel_quad_packer
  import pixel_pkg::*;
#(
  parameter logic [PIX_W-1:0] PAD_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_pix,
  input  logic [PIX_W-1:0]  R,
  input  logic [PIX_W-1:0]  G,
  input  logic [PIX_W-1:0]  B,
`ifdef PIXEL_PACK_LAST_EN
  input  logic              pix_last,
`endif
  output logic              pix_ready,
  output logic              valid_quad,
  output logic [QUAD_W-1:0] R_quad,
  output logic [QUAD_W-1:0] G_quad,
  output logic [QUAD_W-1:0] B_quad,
`ifdef PIXEL_PACK_LAST_EN
  output logic [QUAD_LANES-1:0] quad_mask,
`endif
  input  logic              quad_ready
);

  localparam quad_t PAD_QUAD = quad_t'({3 * QUAD_LANES{PAD_VALUE}});

  pack_state_t state;
  lane_idx_t   idx;
  quad_t       acc;
  quad_t       quad_q;
  quad_t       merged;
  pixel_t      px;
  logic        completing;
  logic        accept;
  logic        drain;

  assign px = '{r: R, g: G, b: B};

`ifdef PIXEL_PACK_LAST_EN
  assign completing = (idx == LAST_LANE) || pix_last;
`else
  assign completing = (idx == LAST_LANE);
`endif

  // Only a completing pixel can collide with a held quad; quad_ready reaches
  // pix_ready combinationally so a drain and a new quad share one edge.
  assign pix_ready = (state == FILLING) || quad_ready || !completing;
  assign accept    = valid_pix && pix_ready;
  assign drain     = (state == HOLDING) && quad_ready;

  // NOTE: every combinational output gets a default before any conditional
  // update, so no latch can be inferred.
  always_comb begin
    merged   = acc;
    merged.r = put_lane(acc.r, idx, px.r);
    merged.g = put_lane(acc.g, idx, px.g);
    merged.b = put_lane(acc.b, idx, px.b);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // accumulator is reset to pad lanes so a reset mid-quad leaves no stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILLING;
      idx    <= '0;
      acc    <= PAD_QUAD;
      quad_q <= '0;
`ifdef PIXEL_PACK_LAST_EN
      quad_mask <= '0;
`endif
    end else begin
      if (accept) begin
        if (completing) begin
          quad_q <= merged;
          acc    <= PAD_QUAD;
          idx    <= '0;
`ifdef PIXEL_PACK_LAST_EN
          quad_mask <= fill_mask(idx);
`endif
        end else begin
          acc <= merged;
          idx <= idx + 1'b1;
        end
      end

      if (accept && completing) begin
        state <= HOLDING;
      end else if (drain) begin
        state <= FILLING;
      end
    end
  end

  assign valid_quad = (state == HOLDING);
  assign R_quad     = quad_q.r;
  assign G_quad     = quad_q.g;
  assign B_quad     = quad_q.b;

endmodule

// File: tb/tb_pixel_quad_packer.sv
// Directed and randomized-gap checks for pixel_quad_packer, with a byte-shift
// scoreboard for the long run. Macro PIXEL_PACK_LAST_EN enables the pix_last vectors.
module tb_pixel_quad_packer;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_pix = 1'b0;
  logic        quad_ready = 1'b0;
  logic [7:0]  R = '0, G = '0, B = '0;
  logic        pix_ready, valid_quad;
  logic [31:0] R_quad, G_quad, B_quad;
`ifdef PIXEL_PACK_LAST_EN
  logic        pix_last = 1'b0;
  logic [3:0]  quad_mask;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pixel_quad_packer #(.PAD_VALUE(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_pix  (valid_pix),
    .R          (R),
    .G          (G),
    .B          (B),
`ifdef PIXEL_PACK_LAST_EN
    .pix_last   (pix_last),
`endif
    .pix_ready  (pix_ready),
    .valid_quad (valid_quad),
    .R_quad     (R_quad),
    .G_quad     (G_quad),
    .B_quad     (B_quad),
`ifdef PIXEL_PACK_LAST_EN
    .quad_mask  (quad_mask),
`endif
    .quad_ready (quad_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic v, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    valid_pix = v;
    R = r;
    G = g;
    B = b;
    #1;
  endtask

  function automatic logic [31:0] seq_quad(input logic [7:0] base, input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(int'(base) + k - 3);
    b1 = 8'(int'(base) + k - 2);
    b2 = 8'(int'(base) + k - 1);
    b3 = 8'(int'(base) + k);
    return {b0, b1, b2, b3};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    quad_t      q_exp[$];
    quad_t      e;
    logic [31:0] m_r, m_g, m_b;
    logic       m_valid, exp_ready;
    int         m_idx, acc_n, cyc, quads;

    // Reset values
    #12;
    check("rst_valid_quad", valid_quad, 0);
    check("rst_R_quad", R_quad, 0);
    check("rst_pix_ready", pix_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single quad, one cycle wide
    quad_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_pix(1'b1, 8'(8'h11 * (i + 1)), 8'(8'hA1 + 8'h11 * i), 8'(i + 1));
      check("q1_ready", pix_ready, 1);
      tick();
      if (i < 3) check("q1_early_valid", valid_quad, 0);
    end
    check("q1_valid", valid_quad, 1);
    check("q1_R", R_quad, 32'h11223344);
    check("q1_G", G_quad, 32'hA1B2C3D4);
    check("q1_B", B_quad, 32'h01020304);
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    check("q1_one_cycle", valid_quad, 0);

    // 16 back-to-back pixels
    for (int k = 1; k <= 16; k++) begin
      set_pix(1'b1, 8'(k), 8'(8'h40 + k), 8'(8'h80 + k));
      check("stream_ready", pix_ready, 1);
      tick();
      if (k % 4 == 0) begin
        check("stream_valid", valid_quad, 1);
        check("stream_R", R_quad, seq_quad(8'h00, k));
        check("stream_G", G_quad, seq_quad(8'h40, k));
        check("stream_B", B_quad, seq_quad(8'h80, k));
      end else begin
        check("stream_gap", valid_quad, 0);
      end
    end
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    check("stream_end", valid_quad, 0);

    // Backpressure: pixels 5-7 flow, pixel 8 stalls until drain
    quad_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      set_pix(1'b1, 8'(8'h20 + k), 8'h00, 8'h00);
      check("bp_ready", pix_ready, 1);
      tick();
      if (k >= 4) begin
        check("bp_held_valid", valid_quad, 1);
        check("bp_held_R", R_quad, 32'h21222324);
      end
    end
    set_pix(1'b1, 8'h28, 8'h00, 8'h00);
    for (int s = 0; s < 3; s++) begin
      check("bp_stall", pix_ready, 0);
      tick();
      check("bp_stable_R", R_quad, 32'h21222324);
    end
    quad_ready = 1'b1;
    #1;
    check("bp_release_ready", pix_ready, 1);
    tick();
    check("bp_swap_valid", valid_quad, 1);
    check("bp_swap_R", R_quad, 32'h25262728);
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    check("bp_drained", valid_quad, 0);

`ifdef PIXEL_PACK_LAST_EN
    // Partial quad flushed by pix_last
    set_pix(1'b1, 8'hAA, 8'h00, 8'h00);
    tick();
    pix_last = 1'b1;
    set_pix(1'b1, 8'hBB, 8'h00, 8'h00);
    tick();
    pix_last = 1'b0;
    check("last_valid", valid_quad, 1);
    check("last_R", R_quad, 32'hAABB0000);
    check("last_mask", 32'(quad_mask), 32'(4'b1100));
    for (int k = 1; k <= 4; k++) begin
      set_pix(1'b1, 8'(k), 8'h00, 8'h00);
      tick();
    end
    check("after_last_R", R_quad, 32'h01020304);
    check("after_last_mask", 32'(quad_mask), 32'(4'b1111));
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick();
`endif

    // Asynchronous reset with a held quad and two buffered pixels
    quad_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_pix(1'b1, 8'(8'h30 + k), 8'h00, 8'h00);
      tick();
    end
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    check("prerst_valid", valid_quad, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid_quad, 0);
    check("async_rst_R", R_quad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quad_ready = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_pix(1'b1, 8'(8'h40 + k), 8'h00, 8'h00);
      tick();
    end
    check("post_rst_valid", valid_quad, 1);
    check("post_rst_R", R_quad, 32'h41424344);
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    tick();

    // Random valid/ready gaps, 10000 pixels, scoreboard
    m_valid = 1'b0;
    m_idx   = 0;
    m_r = '0; m_g = '0; m_b = '0;
    acc_n = 0; cyc = 0; quads = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      quad_ready = ($urandom_range(2) != 0);
      set_pix(($urandom_range(3) != 0), 8'(acc_n), 8'(acc_n) ^ 8'h5A, 8'(acc_n * 3));
      exp_ready = !m_valid || quad_ready || (m_idx != 3);
      check("rnd_ready", pix_ready, exp_ready);
      check("rnd_valid", valid_quad, m_valid);
      if (m_valid && quad_ready) begin
        if (q_exp.size() == 0) begin
          check("rnd_sb_empty", 1, 0);
        end else begin
          e = q_exp.pop_front();
          check("rnd_R", R_quad, e.r);
          check("rnd_G", G_quad, e.g);
          check("rnd_B", B_quad, e.b);
        end
        quads++;
        m_valid = 1'b0;
      end
      if (valid_pix && exp_ready) begin
        m_r = {m_r[23:0], R};
        m_g = {m_g[23:0], G};
        m_b = {m_b[23:0], B};
        if (m_idx == 3) begin
          q_exp.push_back('{r: m_r, g: m_g, b: m_b});
          m_valid = 1'b1;
          m_idx = 0;
        end else begin
          m_idx++;
        end
        acc_n++;
      end
      tick();
      cyc++;
    end
    check("rnd_all_accepted", acc_n, 10000);
    quad_ready = 1'b1;
    set_pix(1'b0, 8'h00, 8'h00, 8'h00);
    if (m_valid) begin
      check("rnd_tail_valid", valid_quad, 1);
      if (q_exp.size() != 0) begin
        e = q_exp.pop_front();
        check("rnd_tail_R", R_quad, e.r);
      end
      quads++;
    end
    tick();
    check("rnd_final_idle", valid_quad, 0);
    check("rnd_quad_count", quads, 2500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_quad_packer.md
# pixel_quad_packer

Collects a stream of single 8-bit RGB pixels into 32-bit packed quads (four pixels per word per channel) and hands each finished quad downstream on a valid/ready handshake. It sits on the write side of the pixel path, ahead of quad-wide memory or a framebuffer writer, and is the inverse of the quad-to-pixel serializer. Byte order matches the serializer: the first pixel of a quad occupies bits [31:24].

## Interface
- PAD_VALUE, 8'h00, byte written into unfilled lanes of a flushed partial quad (only used with PIXEL_PACK_LAST_EN)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_pix  in  1  input pixel valid
- R, G, B  in  8 each  input pixel channels
- pix_last  in  1  marks final pixel of a line/burst (only with PIXEL_PACK_LAST_EN)
- pix_ready  out  1  block accepts the input pixel this cycle
- valid_quad  out  1  output quad valid
- R_quad, G_quad, B_quad  out  32 each  packed channels, pixel 0 at [31:24], pixel 3 at [7:0]
- quad_mask  out  4  lane valid bits, bit 3 = pixel 0 (only with PIXEL_PACK_LAST_EN)
- quad_ready  in  1  downstream accepts the quad this cycle

## Operation
- Pixel accepted when valid_pix && pix_ready. Quad drained when valid_quad && quad_ready.
- 2-bit lane counter idx selects the accumulator byte: accepted pixel goes to bits [31-8*idx -: 8] of each channel accumulator; idx increments, wrapping 3 -> 0.
- A pixel is "completing" when idx == 3, or (with macro) pix_last is high.
- Completing pixel: its byte plus the accumulator are copied into the output register in the same edge; valid_quad set; idx returns to 0; accumulator cleared to PAD_VALUE lanes.
- pix_ready = !valid_quad || quad_ready || !completing. Non-completing pixels are never stalled; a completing pixel stalls only while an undrained quad is held.
- valid_quad cleared on drain unless a completing pixel is accepted the same cycle (then stays high with new data).
- Output register holds value stable while valid_quad && !quad_ready.
- Two states only: FILLING (valid_quad = 0) and HOLDING (valid_quad = 1); the accumulator keeps filling in HOLDING.
- pix_ready must not depend on quad_ready through any register; combinational path quad_ready -> pix_ready is allowed.

## Timing
- Reset values: valid_quad 0, R_quad/G_quad/B_quad 0, quad_mask 0, idx 0, accumulator PAD_VALUE lanes; pix_ready is 1 out of reset.
- Latency: valid_quad rises the cycle after the completing pixel is accepted.
- Sustained throughput: one pixel per cycle, one quad per four cycles, with quad_ready held high.
- Simultaneous drain and completing pixel: both occur, no bubble.
- Reset asserted mid-quad: partial accumulator discarded, no quad emitted.
- valid_pix low mid-quad: idx and accumulator hold indefinitely.

## Configuration
- PIXEL_PACK_LAST_EN defined: pix_last and quad_mask ports exist; pix_last at idx k completes the quad with lanes k+1..3 = PAD_VALUE and quad_mask with the top k+1 bits set; full quads report 4'b1111.
- Undefined: ports absent, PAD_VALUE unused, only idx == 3 completes a quad.

## Structure
- Shared package pixel_pkg: PIX_W = 8, QUAD_LANES = 4, QUAD_W = 32, lane-index typedef, lane-to-bit-offset function reused by the serializer.
- No sub-module; one file, counter, accumulator and output register inline.

## Test plan
- Pixels R = 8'h11, 8'h22, 8'h33, 8'h44 on four consecutive cycles, quad_ready = 1 -> next cycle valid_quad = 1, R_quad = 32'h11223344, one cycle wide.
- Continuous 16 pixels, quad_ready = 1 -> four quads on cycles 5, 9, 13, 17, pix_ready never low.
- quad_ready = 0 after first quad, keep sending -> pixels 5-7 accepted, pixel 8 stalls with pix_ready = 0, R_quad stable; quad_ready = 1 -> drain and pixel 8 accepted the same cycle.
- With PIXEL_PACK_LAST_EN: two pixels 8'hAA, 8'hBB, second with pix_last, PAD_VALUE = 8'h00 -> R_quad = 32'hAABB0000, quad_mask = 4'b1100; next quad starts at lane 0.
- rst_n pulsed low asynchronously after two pixels -> valid_quad 0 immediately; next four pixels form a clean quad with no leftover bytes.
- Random valid_pix/quad_ready gaps over 10,000 pixels -> scoreboard matches in-order quads, no loss or duplication.
